// File: rtl/uart_block_pkg.sv
// Shared encodings and default byte constants for the UART block bridge.
// Used by the RX assembler in the top level and by the TX serializer.
package uart_block_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_FILL = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  localparam logic [7:0] DEFAULT_TERM_BYTE = 8'h0D;
  localparam logic [7:0] DEFAULT_PAD_BYTE  = 8'h00;

endpackage

// File: rtl/block_serializer.sv
// Serialises a captured block MSB-byte-first onto a tx_valid/tx_ack byte
// stream, inserting one idle cycle after every accepted byte.
module block_serializer
  import uart_block_pkg::*;
#(
  parameter int BLOCK_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*BLOCK_BYTES-1:0] core_in,
  input  logic                     core_valid,
  output logic                     core_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ack
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int IW = $clog2(BLOCK_BYTES + 1);

  // Handshakes: core_in is taken on a clock edge where core_valid && core_ready;
  // tx_data is taken on a clock edge where tx_valid && tx_ack.
  tx_state_t       state, state_nxt;
  logic [W-1:0]    sreg, sreg_nxt;
  logic [IW-1:0]   idx, idx_nxt;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    idx_nxt   = idx;
    unique case (state)
      TX_IDLE: begin
        if (core_valid && core_ready) begin
          sreg_nxt  = core_in;
          idx_nxt   = '0;
          state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_ack) begin
          sreg_nxt  = {sreg[W-9:0], sreg[W-1 -: 8]};
          idx_nxt   = idx + 1'b1;
          state_nxt = TX_GAP;
        end
      end
      TX_GAP: begin
        state_nxt = (idx < IW'(BLOCK_BYTES)) ? TX_SEND : TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      sreg       <= '0;
      idx        <= '0;
      core_ready <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      idx        <= idx_nxt;
      core_ready <= (state_nxt == TX_IDLE);
      tx_valid   <= (state_nxt == TX_SEND);
      tx_data    <= (state_nxt == TX_SEND) ? sreg_nxt[W-1 -: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/uart_block_bridge.sv
// Bridges a UART byte stream to fixed-size blocks (RX assembly with optional
// terminator and idle timeout) and serialises result blocks back to bytes.
module uart_block_bridge
  import uart_block_pkg::*;
#(
  parameter int         BLOCK_BYTES = 16,
  parameter bit         TERM_EN     = 1'b1,
  parameter logic [7:0] TERM_BYTE   = DEFAULT_TERM_BYTE,
  parameter logic [7:0] PAD_BYTE    = DEFAULT_PAD_BYTE,
  parameter int         TIMEOUT_CYC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [8*BLOCK_BYTES-1:0] blk_out,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  input  logic [8*BLOCK_BYTES-1:0] core_in,
  input  logic                     core_valid,
  output logic                     core_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ack,
  output logic                     overrun,
  input  logic                     clr_err
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [W-1:0] PAD_FILL = {BLOCK_BYTES{PAD_BYTE}};

  rx_state_t      rx_state, rx_state_nxt;
  logic [W-1:0]   acc, acc_nxt, acc_shift, acc_term;
  logic [CW-1:0]  count, count_nxt;
  logic [TW-1:0]  idle_cnt, idle_cnt_nxt;
  logic           overrun_nxt;
  logic           is_term;
  logic           timeout_hit;
  int             pad_sh;

  assign is_term     = TERM_EN && (rx_data == TERM_BYTE);
  assign timeout_hit = (TIMEOUT_CYC > 0) && (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign acc_shift   = {acc[W-9:0], rx_data};

  // Terminated frame: slide stored bytes to the top, fill the tail with PAD_BYTE.
  always_comb begin
    pad_sh   = 8 * (BLOCK_BYTES - int'(count));
    acc_term = (acc << pad_sh) | (PAD_FILL & ~({W{1'b1}} << pad_sh));
  end

  always_comb begin
    rx_state_nxt = rx_state;
    acc_nxt      = acc;
    count_nxt    = count;
    idle_cnt_nxt = '0;
    overrun_nxt  = clr_err ? 1'b0 : overrun;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_valid && !is_term) begin
          acc_nxt      = {{(W-8){1'b0}}, rx_data};
          count_nxt    = CW'(1);
          rx_state_nxt = RX_FILL;
        end
      end
      RX_FILL: begin
        if (rx_valid) begin
          if (is_term) begin
            acc_nxt      = acc_term;
            rx_state_nxt = RX_HOLD;
          end else begin
            acc_nxt   = acc_shift;
            count_nxt = count + 1'b1;
            if (count == CW'(BLOCK_BYTES - 1)) rx_state_nxt = RX_HOLD;
          end
        end else if (timeout_hit) begin
          acc_nxt      = '0;
          count_nxt    = '0;
          rx_state_nxt = RX_IDLE;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      RX_HOLD: begin
        if (blk_ready) begin
          acc_nxt      = '0;
          count_nxt    = '0;
          rx_state_nxt = RX_IDLE;
          // A byte arriving with the handshake starts the next frame.
          if (rx_valid && !is_term) begin
            acc_nxt      = {{(W-8){1'b0}}, rx_data};
            count_nxt    = CW'(1);
            rx_state_nxt = RX_FILL;
          end
        end else if (rx_valid) begin
          overrun_nxt = 1'b1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      acc      <= '0;
      count    <= '0;
      idle_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      acc      <= acc_nxt;
      count    <= count_nxt;
      idle_cnt <= idle_cnt_nxt;
      overrun  <= overrun_nxt;
    end
  end

  // blk_out/blk_valid handshake: the block is consumed on an edge with both high.
  assign blk_out   = acc;
  assign blk_valid = (rx_state == RX_HOLD);

  block_serializer #(
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .core_in    (core_in),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ack     (tx_ack)
  );

endmodule

// File: tb/tb_uart_block_bridge.sv
// Directed bench for uart_block_bridge: default, TERM_EN=0 and TIMEOUT_CYC=50
// instances share one stimulus bus; each scenario checks the relevant instance.
module tb_uart_block_bridge;
  localparam int BB = 16;
  localparam int W  = 8 * BB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         blk_ready = 1'b0;
  logic [W-1:0] core_in = '0;
  logic         core_valid = 1'b0;
  logic         tx_ack = 1'b0;
  logic         clr_err = 1'b0;

  logic [W-1:0] blk_out, blk_out_nt, blk_out_to;
  logic         blk_valid, blk_valid_nt, blk_valid_to;
  logic         core_ready, core_ready_nt, core_ready_to;
  logic [7:0]   tx_data, tx_data_nt, tx_data_to;
  logic         tx_valid, tx_valid_nt, tx_valid_to;
  logic         overrun, overrun_nt, overrun_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_block_bridge #(.BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .blk_out(blk_out), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .core_in(core_in), .core_valid(core_valid), .core_ready(core_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .overrun(overrun), .clr_err(clr_err));

  uart_block_bridge #(.BLOCK_BYTES(BB), .TERM_EN(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .blk_out(blk_out_nt), .blk_valid(blk_valid_nt), .blk_ready(blk_ready),
    .core_in(core_in), .core_valid(core_valid), .core_ready(core_ready_nt),
    .tx_data(tx_data_nt), .tx_valid(tx_valid_nt), .tx_ack(tx_ack),
    .overrun(overrun_nt), .clr_err(clr_err));

  uart_block_bridge #(.BLOCK_BYTES(BB), .TIMEOUT_CYC(50)) dut_to (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .blk_out(blk_out_to), .blk_valid(blk_valid_to), .blk_ready(blk_ready),
    .core_in(core_in), .core_valid(core_valid), .core_ready(core_ready_to),
    .tx_data(tx_data_to), .tx_valid(tx_valid_to), .tx_ack(tx_ack),
    .overrun(overrun_to), .clr_err(clr_err));

  typedef struct {
    int                n;
    logic [17*8-1:0]   seq;
    logic [W-1:0]      exp;
  } rx_vec_t;

  rx_vec_t vecs[5];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // All driver tasks are entered and left on a falling edge.
  task automatic drive_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; blk_ready = 1'b0; core_valid = 1'b0;
    tx_ack = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic handshake_blk();
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic ack_tx_byte();
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] eb;
    bit         seen_v, seen_b;

    vecs[0] = '{3,  {24'h41420D, 112'h0}, {16'h4142, 112'h0}};
    vecs[1] = '{3,  {24'h0D770D, 112'h0}, {8'h77, 120'h0}};
    vecs[2] = '{16, {128'h101112131415161718191A1B1C1D1E1F, 8'h00},
                128'h101112131415161718191A1B1C1D1E1F};
    vecs[3] = '{16, {128'hF1F2F3F4F5F6F7F8F9FAFBFCFDFEFF0D, 8'h00},
                {120'hF1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 8'h00}};
    vecs[4] = '{2,  {16'hAA0D, 120'h0}, {8'hAA, 120'h0}};

    // Reset values while rst is held, core_ready only after first edge post-release
    @(negedge clk);
    check("rst_blk_out", blk_out, '0);
    check("rst_blk_valid", blk_valid, '0);
    check("rst_tx_data", tx_data, '0);
    check("rst_tx_valid", tx_valid, '0);
    check("rst_core_ready", core_ready, '0);
    check("rst_overrun", overrun, '0);
    rst = 1'b0;
    #1 check("core_ready_before_edge", core_ready, '0);
    @(negedge clk);
    check("core_ready_after_edge", core_ready, 1);

    // Table of RX frames on the terminator-enabled instance
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vecs[v].n; k++) drive_rx(vecs[v].seq[135-8*k -: 8]);
      for (int t = 0; t < 4 && !blk_valid; t++) @(negedge clk);
      check($sformatf("vec%0d_valid", v), blk_valid, 1);
      check($sformatf("vec%0d_blk_out", v), blk_out, vecs[v].exp);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_hold_valid", v), blk_valid, 1);
      check($sformatf("vec%0d_hold_out", v), blk_out, vecs[v].exp);
      handshake_blk();
      check($sformatf("vec%0d_release_valid", v), blk_valid, 0);
      check($sformatf("vec%0d_acc_clear", v), blk_out, '0);
    end

    // 00..0F: full block on TERM_EN=0; the default instance stops at 0x0D
    do_reset();
    for (int k = 0; k < 16; k++) drive_rx(8'(k));
    check("seq_nt_valid", blk_valid_nt, 1);
    check("seq_nt_out", blk_out_nt, 128'h000102030405060708090A0B0C0D0E0F);
    check("seq_term_out", blk_out, {104'h000102030405060708090A0B0C, 24'h0});
    check("seq_term_overrun", overrun, 1);
    repeat (3) @(negedge clk);
    check("seq_nt_hold", blk_out_nt, 128'h000102030405060708090A0B0C0D0E0F);
    handshake_blk();
    check("seq_nt_release", blk_valid_nt, 0);

    // TERM_EN=0 stores the terminator as an ordinary byte
    do_reset();
    drive_rx(8'h41); drive_rx(8'h42); drive_rx(8'h0D);
    for (int k = 3; k < 16; k++) drive_rx(8'(k));
    check("noterm_valid", blk_valid_nt, 1);
    check("noterm_out", blk_out_nt, {24'h41420D, 104'h030405060708090A0B0C0D0E0F});

    // Overrun, sticky until clear, set beats clear, byte on handshake cycle
    do_reset();
    for (int k = 0; k < 16; k++) drive_rx(8'(8'h10 + k));
    check("ovr_full_valid", blk_valid, 1);
    drive_rx(8'h55);
    check("ovr_set", overrun, 1);
    check("ovr_blk_stable", blk_out, 128'h101112131415161718191A1B1C1D1E1F);
    repeat (3) @(negedge clk);
    check("ovr_sticky", overrun, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("ovr_cleared", overrun, 0);
    rx_data = 8'h66; rx_valid = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clr_err = 1'b0;
    check("ovr_set_wins", overrun, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("ovr_cleared2", overrun, 0);
    rx_data = 8'h55; rx_valid = 1'b1; blk_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; blk_ready = 1'b0;
    check("hs_byte_valid_drop", blk_valid, 0);
    check("hs_byte_no_overrun", overrun, 0);
    for (int k = 0; k < 15; k++) drive_rx(8'(8'h60 + k));
    check("hs_next_valid", blk_valid, 1);
    check("hs_next_out", blk_out, {8'h55, 120'h606162636465666768696A6B6C6D6E});
    handshake_blk();

    // TX serialisation with one-cycle-late acks and an ack injected in a gap
    do_reset();
    core_in = 128'h00112233445566778899AABBCCDDEEFF;
    tx_ack = 1'b1; @(negedge clk); tx_ack = 1'b0;
    check("tx_idle_ack_ignored", tx_valid, 0);
    check("tx_ready_idle", core_ready, 1);
    core_valid = 1'b1; @(negedge clk); core_valid = 1'b0;
    check("tx_first_valid", tx_valid, 1);
    for (int k = 0; k < 16; k++) begin
      eb = 8'(k * 17);
      check($sformatf("tx_byte%0d_data", k), tx_data, eb);
      check($sformatf("tx_byte%0d_ready_low", k), core_ready, 0);
      @(negedge clk);
      check($sformatf("tx_byte%0d_held", k), {tx_valid, tx_data}, {1'b1, eb});
      tx_ack = 1'b1; @(negedge clk); tx_ack = 1'b0;
      check($sformatf("tx_byte%0d_gap", k), tx_valid, 0);
      if (k == 5) tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      if (k < 15) check($sformatf("tx_byte%0d_next", k), tx_valid, 1);
      else begin
        check("tx_done_ready", core_ready, 1);
        check("tx_done_valid", tx_valid, 0);
      end
    end

    // Idle timeout discards a partial frame; TIMEOUT_CYC=0 keeps it
    do_reset();
    for (int k = 0; k < 5; k++) drive_rx(8'(8'hA0 + k));
    seen_v = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen_v |= blk_valid_to;
    end
    check("to_no_emit", seen_v, 0);
    for (int k = 0; k < 16; k++) drive_rx(8'(8'h20 + k));
    check("to_clean_valid", blk_valid_to, 1);
    check("to_clean_out", blk_out_to, 128'h202122232425262728292A2B2C2D2E2F);
    check("no_to_out", blk_out, {40'hA0A1A2A3A4, 88'h202122232425262728292A});
    handshake_blk();

    // Reset in the middle of an RX frame and a TX block
    do_reset();
    core_in = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    core_valid = 1'b1; @(negedge clk); core_valid = 1'b0;
    repeat (3) ack_tx_byte();
    check("mid_tx_byte3", {tx_valid, tx_data}, {1'b1, 8'hC3});
    for (int k = 1; k <= 8; k++) drive_rx(8'(8'h30 + k));
    check("mid_rx_partial", blk_out, {64'h0, 64'h3132333435363738});
    rst = 1'b1;
    #1;
    check("mid_rst_blk_out", blk_out, '0);
    check("mid_rst_blk_valid", blk_valid, 0);
    check("mid_rst_tx_data", tx_data, '0);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_core_ready", core_ready, 0);
    check("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rel_ready_low", core_ready, 0);
    @(negedge clk);
    check("mid_rel_ready_high", core_ready, 1);
    seen_v = 1'b0; seen_b = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_v |= tx_valid;
      seen_b |= blk_valid;
    end
    check("mid_no_tx_after_rst", seen_v, 0);
    check("mid_no_blk_after_rst", seen_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
